hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_WAIT, default 2, meaning data-memory wait cycles per M-stage access (0..15; 0 = single-cycle memory).
REQ-002 Clocking: single clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  pipeline clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rsD, rtD  in  5 each  D-stage source register numbers.
REQ-006 rsE, rtE  in  5 each  E-stage source register numbers.
REQ-007 writeregE, writeRegM, writeRegW  in  5 each  destination register per stage.
REQ-008 branchD  in  1  branch in D; regwriteE, regwriteM, regwriteW  in  1 each  stage writes register file.
REQ-009 memtoregE, memtoregM, memwriteM  in  1 each  load in E, load in M, store in M.
REQ-010 stallF, stallD, stallE, stallM  out  1 each  active-high hold of the stage register.
REQ-011 flushE, flushW  out  1 each  insert bubble into E or W register.
REQ-012 forwardAD, forwardBD  out  1 each  D comparator operand from aluoutM.
REQ-013 forwardAE, forwardBE  out  2 each  E operand: 00 register file, 01 resultW, 10 aluoutM.

Function
REQ-014 Forwarding is combinational and never applies to register 0.
REQ-015 forwardAE = 10 if regwriteM and writeRegM==rsE; else 01 if regwriteW and writeRegW==rsE; else 00. M wins when M and W both match. forwardBE is identical using rtE.
REQ-016 forwardAD = regwriteM and writeRegM==rsD; forwardBD = regwriteM and writeRegM==rtD.
REQ-017 lwstall = memtoregE and (rtE==rsD or rtE==rtD).
REQ-018 brstall = branchD and ((regwriteE and writeregE in {rsD,rtD}) or (memtoregM and writeRegM in {rsD,rtD})).
REQ-019 memop = memtoregM or memwriteM. Memory FSM states are IDLE, WAIT and RELEASE; 4-bit down-counter cnt.
REQ-020 IDLE: if memop and MEM_WAIT>0, then memstall=1, cnt<=MEM_WAIT-1, next = RELEASE if MEM_WAIT==1, else WAIT. Otherwise stay in IDLE with memstall=0.
REQ-021 WAIT: memstall=1 and cnt<=cnt-1; when cnt==1, next RELEASE.
REQ-022 RELEASE: memstall=0, so the instruction in M advances this edge; next IDLE. A memop arriving next cycle restarts in IDLE.
REQ-023 With memstall=1: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0. memstall overrides lwstall/brstall.
REQ-024 With memstall=0: stallF=stallD=flushE=(lwstall or brstall); stallE=stallM=flushW=0.
REQ-025 Total latency per memop is MEM_WAIT+1 cycles in M. With MEM_WAIT=0 the FSM stays in IDLE permanently.

Reset
REQ-026 Reset forces state=IDLE and cnt=0; while reset is high, all outputs are 0.
REQ-027 Reset asserted mid-WAIT abandons the access; the first cycle after release evaluates from IDLE.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN, when defined, adds 32-bit outputs lwstall_cnt, brstall_cnt and memstall_cnt.
REQ-029 Each counter increments on every cycle its condition drives stalls, including lwstall/brstall only when not masked by memstall. Counters saturate at all-ones and reset to 0.
REQ-030 Without HAZARD_PERF_CNT_EN the ports and registers are absent; all other behaviour is identical.

Structure
REQ-031 Package hazard_pkg holds: fwd_sel_t (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_t (IDLE, WAIT, RELEASE), and REG_ZERO=5'd0.
REQ-032 Sub-module fwd_select computes one 2-bit E-stage select from (src, writeRegM, regwriteM, writeRegW, regwriteW); it is instantiated twice.

Verification
REQ-033 Forward priority: regwriteM=1, writeRegM=5, regwriteW=1, writeRegW=5, rsE=5 -> forwardAE=10. Same case with rsE=0 -> forwardAE=00.
REQ-034 Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for exactly that cycle.
REQ-035 Branch: branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stall. Next cycle regwriteM=1, writeRegM=3 gives forwardBD=1 and no stall.
REQ-036 MEM_WAIT=2, memtoregM=1 held -> stallM=flushW=1 for 2 cycles, 0 on the 3rd cycle, FSM back in IDLE. A concurrent lwstall produces no flushE during those cycles.
REQ-037 Reset pulse during WAIT (MEM_WAIT=3) -> all outputs 0 immediately; a new memop after release stalls a full 3 cycles.
REQ-038 With HAZARD_PERF_CNT_EN defined, sequence REQ-034, REQ-035, REQ-036 -> lwstall_cnt=1, brstall_cnt=1, memstall_cnt=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and helpers for the pipeline hazard unit.
//   fwd_sel_t   : E-stage operand source (register file, W result, M ALU output)
//   mem_state_t : data-memory wait sequencer states
//   REG_ZERO    : hard-wired zero register, never a forwarding target
//   regMatch    : "this stage writes the register being read" test
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register 0 always reads as zero, so a write to it must never be forwarded.
  function automatic logic regMatch(input logic wen, input logic [4:0] dst,
                                    input logic [4:0] src);
    return wen && (dst == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// fwd_select
// Chooses the source of one E-stage ALU operand.
//   src        in  5  E-stage source register number
//   writeRegM  in  5  destination register of the instruction in M
//   regwriteM  in  1  instruction in M writes the register file
//   writeRegW  in  5  destination register of the instruction in W
//   regwriteW  in  1  instruction in W writes the register file
//   sel        out 2  FWD_M, FWD_W or FWD_RF
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] writeRegM,
  input  logic       regwriteM,
  input  logic [4:0] writeRegW,
  input  logic       regwriteW,
  output fwd_sel_t   sel
);

  // M is checked first because it holds the younger, more recent value.
  always_comb begin
    sel = FWD_RF;
    if (regMatch(regwriteM, writeRegM, src)) begin
      sel = FWD_M;
    end else if (regMatch(regwriteW, writeRegW, src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Forwarding, stall and flush control for a 5-stage pipeline with a
// multi-cycle data memory (MEM_WAIT wait cycles per M-stage access).
//   clk, reset                    clock and asynchronous active-high reset
//   rsD, rtD, rsE, rtE            source registers in D and E
//   writeregE/writeRegM/writeRegW destination register per stage
//   branchD, regwriteE/M/W        branch in D, register-write per stage
//   memtoregE/M, memwriteM        load in E/M, store in M
//   stallF/D/E/M, flushE/flushW   pipeline register hold and bubble controls
//   forwardAD/BD                  D comparator operand from aluoutM
//   forwardAE/BE                  E operand select (00 RF, 01 resultW, 10 aluoutM)
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit stall counters
// lwstall_cnt, brstall_cnt and memstall_cnt.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       branchD,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       memwriteM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushE,
  output logic       flushW,
  output logic       forwardAD,
  output logic       forwardBD,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] lwstall_cnt,
  output logic [31:0] brstall_cnt,
  output logic [31:0] memstall_cnt,
`endif
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  mem_state_t state, stateNext;
  logic [3:0] cnt, cntNext;
  logic       memop, memstall, lwstall, brstall;
  fwd_sel_t   selAE, selBE;

  fwd_select uFwdA (
    .src(rsE), .writeRegM(writeRegM), .regwriteM(regwriteM),
    .writeRegW(writeRegW), .regwriteW(regwriteW), .sel(selAE)
  );

  fwd_select uFwdB (
    .src(rtE), .writeRegM(writeRegM), .regwriteM(regwriteM),
    .writeRegW(writeRegW), .regwriteW(regwriteW), .sel(selBE)
  );

  assign memop   = memtoregM | memwriteM;
  assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign brstall = branchD &&
                   ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                    (memtoregM && ((writeRegM == rsD) || (writeRegM == rtD))));

  // Memory sequencer state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The first stall cycle is raised straight from IDLE so the access costs
  // MEM_WAIT stall cycles plus one RELEASE cycle in which M advances.
  // RELEASE never restarts, so back-to-back accesses each pay full latency.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    memstall  = 1'b0;
    case (state)
      IDLE: begin
        if (memop && (MEM_WAIT > 0)) begin
          memstall  = 1'b1;
          cntNext   = WAIT_LOAD;
          stateNext = (MEM_WAIT == 1) ? RELEASE : WAIT;
        end
      end
      WAIT: begin
        memstall = 1'b1;
        cntNext  = cnt - 4'd1;
        if (cnt == 4'd1) begin
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // A memory stall freezes the whole front of the pipe and bubbles W; it
  // takes precedence over load-use and branch stalls. Everything is held
  // low while reset is asserted, including the combinational forwards.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (!reset) begin
      forwardAD = regMatch(regwriteM, writeRegM, rsD);
      forwardBD = regMatch(regwriteM, writeRegM, rtD);
      forwardAE = selAE;
      forwardBE = selBE;
      if (memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else begin
        stallF = lwstall | brstall;
        stallD = lwstall | brstall;
        flushE = lwstall | brstall;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Count only cycles where the condition actually drives the stall outputs;
  // load-use and branch stalls hidden behind a memory stall are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lwstall_cnt  <= 32'd0;
      brstall_cnt  <= 32'd0;
      memstall_cnt <= 32'd0;
    end else begin
      if (memstall && (memstall_cnt != 32'hFFFF_FFFF)) begin
        memstall_cnt <= memstall_cnt + 32'd1;
      end
      if (!memstall && lwstall && (lwstall_cnt != 32'hFFFF_FFFF)) begin
        lwstall_cnt <= lwstall_cnt + 32'd1;
      end
      if (!memstall && brstall && (brstall_cnt != 32'hFFFF_FFFF)) begin
        brstall_cnt <= brstall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Drives two hazard_unit instances (MEM_WAIT=2 and MEM_WAIT=3) from the same
// inputs and compares every output against a behavioural model each cycle.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeRegM, writeRegW;
  logic       branchD, regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM, memwriteM;

  logic       stallF [2];
  logic       stallD [2];
  logic       stallE [2];
  logic       stallM [2];
  logic       flushE [2];
  logic       flushW [2];
  logic       forwardAD [2];
  logic       forwardBD [2];
  logic [1:0] forwardAE [2];
  logic [1:0] forwardBE [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lwCnt [2];
  logic [31:0] brCnt [2];
  logic [31:0] msCnt [2];
  logic [31:0] expLw [2];
  logic [31:0] expBr [2];
  logic [31:0] expMs [2];
`endif

  int checkCount = 0;
  int passCount  = 0;
  // Cycles already spent in the current memory access, -1 when none.
  int modelAge [2];

  always #5 clk = ~clk;

  hazard_unit #(.MEM_WAIT(2)) u2 (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .branchD(branchD), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .memwriteM(memwriteM),
    .stallF(stallF[0]), .stallD(stallD[0]), .stallE(stallE[0]), .stallM(stallM[0]),
    .flushE(flushE[0]), .flushW(flushW[0]),
    .forwardAD(forwardAD[0]), .forwardBD(forwardBD[0]),
`ifdef HAZARD_PERF_CNT_EN
    .lwstall_cnt(lwCnt[0]), .brstall_cnt(brCnt[0]), .memstall_cnt(msCnt[0]),
`endif
    .forwardAE(forwardAE[0]), .forwardBE(forwardBE[0])
  );

  hazard_unit #(.MEM_WAIT(3)) u3 (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .branchD(branchD), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .memwriteM(memwriteM),
    .stallF(stallF[1]), .stallD(stallD[1]), .stallE(stallE[1]), .stallM(stallM[1]),
    .flushE(flushE[1]), .flushW(flushW[1]),
    .forwardAD(forwardAD[1]), .forwardBD(forwardBD[1]),
`ifdef HAZARD_PERF_CNT_EN
    .lwstall_cnt(lwCnt[1]), .brstall_cnt(brCnt[1]), .memstall_cnt(msCnt[1]),
`endif
    .forwardAE(forwardAE[1]), .forwardBE(forwardBE[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic int mwOf(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [1:0] fwdModel(input logic [4:0] src);
    if (src != 5'd0 && regwriteM && writeRegM == src) return 2'b10;
    if (src != 5'd0 && regwriteW && writeRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeregE = 5'd0; writeRegM = 5'd0; writeRegW = 5'd0;
    branchD = 1'b0; regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; memwriteM = 1'b0;
  endtask

  // Small register range so that matches between stages happen often.
  task automatic applyStimulus();
    reset     = ($urandom_range(0, 39) == 0);
    rsD       = 5'($urandom_range(0, 3));
    rtD       = 5'($urandom_range(0, 3));
    rsE       = 5'($urandom_range(0, 3));
    rtE       = 5'($urandom_range(0, 3));
    writeregE = 5'($urandom_range(0, 3));
    writeRegM = 5'($urandom_range(0, 3));
    writeRegW = 5'($urandom_range(0, 3));
    branchD   = ($urandom_range(0, 2) == 0);
    regwriteE = $urandom_range(0, 1) == 1;
    regwriteM = $urandom_range(0, 1) == 1;
    regwriteW = $urandom_range(0, 1) == 1;
    memtoregE = ($urandom_range(0, 2) == 0);
    memtoregM = ($urandom_range(0, 4) == 0);
    memwriteM = ($urandom_range(0, 5) == 0);
  endtask

  // Called just after a falling edge with inputs applied: checks both
  // instances against the model, advances the model across the coming
  // rising edge, and returns at the next falling edge.
  task automatic evalCycle();
    logic lw, br, ms, haz;
    logic [1:0] eAE, eBE;
    logic eAD, eBD;
    int curAge;
    string p;
    #1;
    lw  = memtoregE && (rtE == rsD || rtE == rtD);
    br  = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                      (memtoregM && (writeRegM == rsD || writeRegM == rtD)));
    haz = lw || br;
    eAE = fwdModel(rsE);
    eBE = fwdModel(rtE);
    eAD = regwriteM && rsD != 5'd0 && writeRegM == rsD;
    eBD = regwriteM && rtD != 5'd0 && writeRegM == rtD;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "mw2" : "mw3";
      if (reset) curAge = -1;
      else if (modelAge[i] >= 0) curAge = modelAge[i];
      else if ((memtoregM || memwriteM) && mwOf(i) > 0) curAge = 0;
      else curAge = -1;
      ms = (curAge >= 0) && (curAge < mwOf(i));
      checkOutput({p, ".stallF"}, 32'(stallF[i]), 32'(!reset && (ms || haz)));
      checkOutput({p, ".stallD"}, 32'(stallD[i]), 32'(!reset && (ms || haz)));
      checkOutput({p, ".stallE"}, 32'(stallE[i]), 32'(!reset && ms));
      checkOutput({p, ".stallM"}, 32'(stallM[i]), 32'(!reset && ms));
      checkOutput({p, ".flushE"}, 32'(flushE[i]), 32'(!reset && !ms && haz));
      checkOutput({p, ".flushW"}, 32'(flushW[i]), 32'(!reset && ms));
      checkOutput({p, ".forwardAD"}, 32'(forwardAD[i]), 32'(!reset && eAD));
      checkOutput({p, ".forwardBD"}, 32'(forwardBD[i]), 32'(!reset && eBD));
      checkOutput({p, ".forwardAE"}, 32'(forwardAE[i]), reset ? 32'd0 : 32'(eAE));
      checkOutput({p, ".forwardBE"}, 32'(forwardBE[i]), reset ? 32'd0 : 32'(eBE));
`ifdef HAZARD_PERF_CNT_EN
      if (reset) begin
        expLw[i] = 32'd0; expBr[i] = 32'd0; expMs[i] = 32'd0;
      end
      checkOutput({p, ".lwCnt"}, lwCnt[i], expLw[i]);
      checkOutput({p, ".brCnt"}, brCnt[i], expBr[i]);
      checkOutput({p, ".msCnt"}, msCnt[i], expMs[i]);
      if (!reset) begin
        if (ms && expMs[i] != 32'hFFFF_FFFF) expMs[i] = expMs[i] + 32'd1;
        if (!ms && lw && expLw[i] != 32'hFFFF_FFFF) expLw[i] = expLw[i] + 32'd1;
        if (!ms && br && expBr[i] != 32'hFFFF_FFFF) expBr[i] = expBr[i] + 32'd1;
      end
`endif
      modelAge[i] = (!reset && curAge >= 0 && curAge < mwOf(i)) ? curAge + 1 : -1;
    end
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      modelAge[i] = -1;
`ifdef HAZARD_PERF_CNT_EN
      expLw[i] = 32'd0; expBr[i] = 32'd0; expMs[i] = 32'd0;
`endif
    end
    @(negedge clk);
    evalCycle();
    reset = 1'b0;

    // Forwarding priority and the zero register
    regwriteM = 1'b1; writeRegM = 5'd5; regwriteW = 1'b1; writeRegW = 5'd5; rsE = 5'd5;
    #1 checkOutput("prioM", 32'(forwardAE[0]), 32'd2);
    evalCycle();
    rsE = 5'd0;
    #1 checkOutput("reg0", 32'(forwardAE[0]), 32'd0);
    evalCycle();

    // Load-use stall lasts exactly one cycle
    clearInputs();
    memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    #1 checkOutput("lwStallF", 32'(stallF[0]), 32'd1);
    checkOutput("lwFlushE", 32'(flushE[0]), 32'd1);
    evalCycle();
    clearInputs();
    #1 checkOutput("lwGone", 32'(stallF[0]), 32'd0);
    evalCycle();

    // Branch stall then forward from M
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rtD = 5'd3;
    #1 checkOutput("brStallD", 32'(stallD[0]), 32'd1);
    evalCycle();
    clearInputs();
    branchD = 1'b1; rtD = 5'd3; regwriteM = 1'b1; writeRegM = 5'd3;
    #1 checkOutput("brFwdBD", 32'(forwardBD[0]), 32'd1);
    checkOutput("brNoStall", 32'(stallF[0]), 32'd0);
    evalCycle();

    // Memory wait with a masked load-use stall
    clearInputs();
    memtoregM = 1'b1; memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    for (int c = 0; c < 2; c++) begin
      #1 checkOutput("memStallM", 32'(stallM[0]), 32'd1);
      checkOutput("memFlushW", 32'(flushW[0]), 32'd1);
      checkOutput("memNoFlushE", 32'(flushE[0]), 32'd0);
      evalCycle();
    end
    memtoregE = 1'b0; rtE = 5'd0; rsD = 5'd0;
    #1 checkOutput("memRelease", 32'(stallM[0]), 32'd0);
    evalCycle();
    clearInputs();
    evalCycle();
`ifdef HAZARD_PERF_CNT_EN
    #1 checkOutput("cntLw", lwCnt[0], 32'd1);
    checkOutput("cntBr", brCnt[0], 32'd1);
    checkOutput("cntMs", msCnt[0], 32'd2);
`endif
    evalCycle();

    // Reset in the middle of a MEM_WAIT=3 access, then a full new access
    memtoregM = 1'b1;
    evalCycle();
    reset = 1'b1;
    #1 checkOutput("rstStallM", 32'(stallM[1]), 32'd0);
    checkOutput("rstStallF", 32'(stallF[1]), 32'd0);
    checkOutput("rstFlushW", 32'(flushW[1]), 32'd0);
    evalCycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput("postRstStall", 32'(stallM[1]), 32'd1);
      evalCycle();
    end
    #1 checkOutput("postRstRelease", 32'(stallM[1]), 32'd0);
    evalCycle();
    clearInputs();
    evalCycle();

    repeat (400) begin
      applyStimulus();
      evalCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
